tk_dr_sync_rx: RTL and testbench

TK_DR_SYNC_RX -- requirements
Module: tk_dr_sync_rx

---
 rtl/tk_dr_sync_rx.sv | 186 ++++++++++++++++++
 tb/tb_tk_dr_sync_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tk_dr_sync_rx.sv
// rtl/tk_dr_sync_rx.sv - dual-rail 4-phase async receiver with synchronisers and receive FIFO
// Optional illegal-code (both rails high) detection under `TK_DR_RX_ILLEGAL_DET_EN.
module tk_dr_sync_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_r0,
    input  logic [WIDTH-1:0] in_r1,
    output logic             in_a,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_RTZ  = 1'b1
    } state_t;

    state_t            state_q;
    logic              in_a_q;
    logic              run_q;

    logic [WIDTH-1:0]  r0_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  r1_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  r0_sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]  r1_sync_d [SYNC_STAGES];

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              stage_valid_q, stage_valid_d;
    logic [WIDTH-1:0]  stage_data_q, stage_data_d;

    logic [WIDTH-1:0]  r0_s, r1_s;
    logic [CW-1:0]     occ;
    logic              complete, spacer, pop, space, push_fire;

    // Holds all state still for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_comb begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
            r0_sync_d[s] = r0_sync_q[s];
            r1_sync_d[s] = r1_sync_q[s];
        end
        if (run_q) begin
            r0_sync_d[0] = in_r0;
            r1_sync_d[0] = in_r1;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r0_sync_d[s] = r0_sync_q[s-1];
                r1_sync_d[s] = r1_sync_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r0_sync_q[s] <= '0;
                r1_sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r0_sync_q[s] <= r0_sync_d[s];
                r1_sync_q[s] <= r1_sync_d[s];
            end
        end
    end

    // The staged word lands in the FIFO one edge after the acknowledge, so
    // occupancy counts it; the stage always drains because occ never exceeds DEPTH.
    always_comb begin
        r0_s      = r0_sync_q[SYNC_STAGES-1];
        r1_s      = r1_sync_q[SYNC_STAGES-1];
        complete  = &(r0_s ^ r1_s);
        spacer    = ~|(r0_s | r1_s);
        pop       = (count_q != '0) && out_ready;
        occ       = count_q + CW'(stage_valid_q);
        space     = (occ < CW'(DEPTH)) || ((occ == CW'(DEPTH)) && pop);
        push_fire = run_q && (state_q == WAIT_DATA) && complete && space;

        stage_valid_d = push_fire;
        stage_data_d  = push_fire ? r1_s : stage_data_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (stage_valid_q) begin
            mem_d[wr_ptr_q] = stage_data_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(stage_valid_q) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_DATA;
            in_a_q  <= 1'b0;
        end else if (run_q) begin
            case (state_q)
                WAIT_DATA: begin
                    if (push_fire) begin
                        in_a_q  <= 1'b1;
                        state_q <= WAIT_RTZ;
                    end
                end
                WAIT_RTZ: begin
                    if (spacer) begin
                        in_a_q  <= 1'b0;
                        state_q <= WAIT_DATA;
                    end
                end
                default: begin
                    in_a_q  <= 1'b0;
                    state_q <= WAIT_DATA;
                end
            endcase
        end
    end

`ifdef TK_DR_RX_ILLEGAL_DET_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (run_q & (|(r0_s & r1_s)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_a      = in_a_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_tk_dr_sync_rx.sv
// tb/tb_tk_dr_sync_rx.sv - scoreboard bench for tk_dr_sync_rx (WIDTH=8, SYNC_STAGES=2, DEPTH=2)
module tb_tk_dr_sync_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_r0, in_r1;
    logic       in_a;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pops   = 0;
    logic [7:0] exp_q [$];

    tk_dr_sync_rx #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_r0     (in_r0),
        .in_r1     (in_r1),
        .in_a      (in_a),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
                n_pops++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic level, input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            step();
            if (in_a === level) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 32'(in_a), 32'(level));
    endtask

    task automatic send(input logic [7:0] w, input int exp_lat);
        int lat;
        exp_q.push_back(w);
        in_r1 = w;
        in_r0 = ~w;
        wait_ack(1'b1, 40, lat);
        if (exp_lat > 0) chk("ack_latency", 32'(lat), 32'(exp_lat));
        in_r1 = '0;
        in_r0 = '0;
        wait_ack(1'b0, 40, lat);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pops0;
        logic seen;
        logic [7:0] w;

        rst_n = 1'b0; in_r0 = '0; in_r1 = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_in_a", 32'(in_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // basic word, latency of ack and valid, ack release
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        in_r1 = 8'hA5; in_r0 = 8'h5A;
        wait_ack(1'b1, 40, lat);
        chk("basic_ack_lat", 32'(lat), 32'd3);
        chk("basic_valid_pre", 32'(out_valid), 32'd0);
        step();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'hA5);
        in_r1 = '0; in_r0 = '0;
        wait_ack(1'b0, 40, lat);
        chk("basic_rtz_lat", 32'(lat), 32'd3);
        drain();

        // backpressure: third word must wait for a pop
        out_ready = 1'b0;
        send(8'h01, 3);
        send(8'h02, 3);
        exp_q.push_back(8'h03);
        in_r1 = 8'h03; in_r0 = 8'hFC;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (in_a) seen = 1'b1;
        end
        chk("full_no_ack", 32'(seen), 32'd0);
        chk("full_head", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        wait_ack(1'b1, 40, lat);
        in_r1 = '0; in_r0 = '0;
        wait_ack(1'b0, 40, lat);
        drain();

        // rails arriving one bit at a time
        pops0 = n_pops;
        w = 8'h3C;
        exp_q.push_back(w);
        in_r1 = '0; in_r0 = '0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) in_r1[i] = 1'b1;
            else      in_r0[i] = 1'b1;
            if (i < 7) begin
                step();
                if (in_a) seen = 1'b1;
            end
        end
        chk("partial_no_ack", 32'(seen), 32'd0);
        wait_ack(1'b1, 40, lat);
        chk("partial_ack_lat", 32'(lat), 32'd3);
        in_r1 = '0; in_r0 = '0;
        wait_ack(1'b0, 40, lat);
        drain();
        repeat (4) step();
        chk("partial_one_push", 32'(n_pops - pops0), 32'd1);

        // full FIFO: pop and push on the same edge
        out_ready = 1'b0;
        send(8'h11, 3);
        send(8'h22, 3);
        exp_q.push_back(8'h33);
        in_r1 = 8'h33; in_r0 = 8'hCC;
        step();
        step();
        out_ready = 1'b1;
        step();
        chk("same_cycle_ack", 32'(in_a), 32'd1);
        chk("same_cycle_valid", 32'(out_valid), 32'd1);
        chk("same_cycle_head", 32'(out_data), 32'h22);
        in_r1 = '0; in_r0 = '0;
        wait_ack(1'b0, 40, lat);
        drain();

        // reset while waiting for return-to-zero
        out_ready = 1'b0;
        exp_q.push_back(8'h44);
        in_r1 = 8'h44; in_r0 = 8'hBB;
        wait_ack(1'b1, 40, lat);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("rtz_rst_in_a", 32'(in_a), 32'd0);
        chk("rtz_rst_valid", 32'(out_valid), 32'd0);
        void'(exp_q.pop_back());
        in_r1 = 8'h55; in_r0 = 8'hAA;
        exp_q.push_back(8'h55);
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        wait_ack(1'b1, 40, lat);
        chk("post_rst_ack_lat", 32'(lat), 32'd4);
        in_r1 = '0; in_r0 = '0;
        wait_ack(1'b0, 40, lat);
        drain();

        // both rails high on bit 3
        pops0 = n_pops;
        in_r1 = 8'h0F; in_r0 = 8'hF8;
        step();
        step();
        chk("illegal_err_early", 32'(err), 32'd0);
        step();
`ifdef TK_DR_RX_ILLEGAL_DET_EN
        chk("illegal_err_set", 32'(err), 32'd1);
`else
        chk("illegal_err_tied", 32'(err), 32'd0);
`endif
        seen = in_a;
        for (int k = 0; k < 10; k++) begin
            step();
            if (in_a) seen = 1'b1;
        end
        chk("illegal_no_ack", 32'(seen), 32'd0);
        in_r1 = '0; in_r0 = '0;
        repeat (6) step();
`ifdef TK_DR_RX_ILLEGAL_DET_EN
        chk("illegal_err_sticky", 32'(err), 32'd1);
`else
        chk("illegal_err_sticky", 32'(err), 32'd0);
`endif
        chk("illegal_no_push", 32'(n_pops - pops0), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("illegal_err_rst", 32'(err), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
